// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: round-robin or fixed m0 priority,
// one access in flight, read data routed back to the owner, watchdog on read completion.
//   state     | meaning
//   S_IDLE    | arbitrate, issue writes/no-ops, launch reads
//   S_RD_WAIT | read in flight, waiting for mem_rvalid or watchdog expiry
module dmem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 16,
  parameter int M0_PRIORITY = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_ren,
  input  logic [1:0]    m0_wen,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_ren,
  input  logic [1:0]    m1_wen,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_ren,
  output logic [1:0]    mem_wen,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          err_timeout,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WDOG_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] WDOG_LAST = TW'(1);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner, r_last_owner;
  logic [AW-1:0] r_addr;
  logic [TW-1:0] r_wdog;
  logic          r_err;
  logic          r_m0_rvalid, r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  logic          w_gnt0, w_gnt1, w_any_gnt;
  logic [AW-1:0] w_addr_sel;
  logic          w_ren_sel;
  logic [1:0]    w_wen_sel;
  logic [DW-1:0] w_wdata_sel;
  logic          w_is_write, w_is_read;
  logic          w_rd_done, w_rd_expire;

  // Grants are gated by reset so nothing leaks to memory while reset is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset && (r_state == S_IDLE)) begin
      if (m0_req && m1_req) begin
        if ((M0_PRIORITY != 0) || r_last_owner) w_gnt0 = 1'b1;
        else                                    w_gnt1 = 1'b1;
      end else if (m0_req) begin
        w_gnt0 = 1'b1;
      end else if (m1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_any_gnt   = w_gnt0 | w_gnt1;
  assign w_addr_sel  = w_gnt1 ? m1_addr  : m0_addr;
  assign w_ren_sel   = w_gnt1 ? m1_ren   : m0_ren;
  assign w_wen_sel   = w_gnt1 ? m1_wen   : m0_wen;
  assign w_wdata_sel = w_gnt1 ? m1_wdata : m0_wdata;
  assign w_is_write  = |w_wen_sel;
  assign w_is_read   = w_ren_sel & ~w_is_write;

  assign w_rd_done   = (r_state == S_RD_WAIT) && mem_rvalid;
  assign w_rd_expire = (r_state == S_RD_WAIT) && !mem_rvalid && (r_wdog == WDOG_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any_gnt && w_is_read)  w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (w_rd_done || w_rd_expire) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_addr       <= '0;
      r_wdog       <= '0;
      r_err        <= 1'b0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_any_gnt) r_last_owner <= w_gnt1;
      if (w_any_gnt && w_is_read) begin
        r_owner <= w_gnt1;
        r_addr  <= w_addr_sel;
        r_wdog  <= WDOG_LOAD;
      end else if ((r_state == S_RD_WAIT) && !mem_rvalid) begin
        r_wdog <= r_wdog - WDOG_LAST;
      end
      r_m0_rvalid <= w_rd_done && !r_owner;
      r_m1_rvalid <= w_rd_done &&  r_owner;
      if (w_rd_done && !r_owner) r_m0_rdata <= mem_rdata;
      if (w_rd_done &&  r_owner) r_m1_rdata <= mem_rdata;
      if (w_rd_expire) r_err <= 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_ren   = 1'b0;
    mem_wen   = 2'b00;
    mem_wdata = '0;
    if (r_state == S_RD_WAIT) begin
      mem_addr = r_addr;
    end else if (w_any_gnt) begin
      mem_addr  = w_addr_sel;
      mem_ren   = w_is_read;
      mem_wen   = w_wen_sel;
      mem_wdata = w_wdata_sel;
    end
  end

  assign m0_gnt      = w_gnt0;
  assign m1_gnt      = w_gnt1;
  assign m0_rvalid   = r_m0_rvalid;
  assign m1_rvalid   = r_m1_rvalid;
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign err_timeout = r_err;
  assign busy        = (r_state == S_RD_WAIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and an m0-priority instance
// share the same stimulus; expected values are hand-computed per cycle.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          m0_req, m1_req, m0_ren, m1_ren;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [1:0]    m0_wen, m1_wen;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [1:0]    mem_wen;
  logic [DW-1:0] mem_wdata;
  logic          err_timeout, busy;

  logic          p_m0_gnt, p_m1_gnt, p_m0_rvalid, p_m1_rvalid;
  logic [DW-1:0] p_m0_rdata, p_m1_rdata;
  logic [AW-1:0] p_mem_addr;
  logic          p_mem_ren;
  logic [1:0]    p_mem_wen;
  logic [DW-1:0] p_mem_wdata;
  logic          p_err_timeout, p_busy;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16), .M0_PRIORITY(0)) u_dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .err_timeout(err_timeout), .busy(busy)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16), .M0_PRIORITY(1)) u_dut_prio (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_gnt(p_m0_gnt), .m0_rdata(p_m0_rdata), .m0_rvalid(p_m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_gnt(p_m1_gnt), .m1_rdata(p_m1_rdata), .m1_rvalid(p_m1_rvalid),
    .mem_addr(p_mem_addr), .mem_ren(p_mem_ren), .mem_wen(p_mem_wen), .mem_wdata(p_mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .err_timeout(p_err_timeout), .busy(p_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_ren = 1'b0; m0_wen = 2'b00; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_ren = 1'b0; m1_wen = 2'b00; m1_addr = '0; m1_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  n_busy;
    bit  rv_seen;
    bit  err_early;

    reset = 1'b0;
    mem_rdata = '0;
    mem_rvalid = 1'b0;
    idle_inputs();

    // reset values, with a request held during reset
    step();
    m0_req = 1'b1; m0_ren = 1'b1; m0_addr = 32'h55;
    smp();
    chk("rst_m0_gnt",  64'(m0_gnt),      64'd0);
    chk("rst_m1_gnt",  64'(m1_gnt),      64'd0);
    chk("rst_mem_ren", 64'(mem_ren),     64'd0);
    chk("rst_mem_wen", 64'(mem_wen),     64'd0);
    chk("rst_mem_addr",64'(mem_addr),    64'd0);
    chk("rst_err",     64'(err_timeout), 64'd0);
    chk("rst_busy",    64'(busy),        64'd0);
    chk("rst_rvalid",  64'(m0_rvalid),   64'd0);
    step();
    idle_inputs();
    reset = 1'b1;

    // S1: m0 read, memory answers one cycle after entry
    step();
    m0_req = 1'b1; m0_ren = 1'b1; m0_addr = 32'h10;
    smp();
    chk("s1_m0_gnt",   64'(m0_gnt),   64'd1);
    chk("s1_m1_gnt",   64'(m1_gnt),   64'd0);
    chk("s1_mem_ren",  64'(mem_ren),  64'd1);
    chk("s1_mem_addr", 64'(mem_addr), 64'h10);
    step();
    idle_inputs();
    smp();
    chk("s1_busy",      64'(busy),     64'd1);
    chk("s1_ren_once",  64'(mem_ren),  64'd0);
    chk("s1_addr_hold", 64'(mem_addr), 64'h10);
    chk("s1_no_gnt",    64'(m0_gnt),   64'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h93;
    smp();
    chk("s1_rv_early", 64'(m0_rvalid), 64'd0);
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("s1_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("s1_m0_rdata",  64'(m0_rdata),  64'h93);
    chk("s1_m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("s1_idle",      64'(busy),      64'd0);
    step();
    smp();
    chk("s1_rv_pulse",  64'(m0_rvalid), 64'd0);
    chk("s1_rdata_hold",64'(m0_rdata),  64'h93);

    // S4: tie after m0 owned last -> m1 read wins, m0 write held off
    step();
    m1_req = 1'b1; m1_ren = 1'b1; m1_addr = 32'h40;
    m0_req = 1'b1; m0_wen = 2'b11; m0_addr = 32'h100; m0_wdata = 32'hA5A5;
    smp();
    chk("s4_m1_gnt",   64'(m1_gnt),   64'd1);
    chk("s4_m0_gnt",   64'(m0_gnt),   64'd0);
    chk("s4_mem_ren",  64'(mem_ren),  64'd1);
    chk("s4_mem_wen",  64'(mem_wen),  64'd0);
    chk("s4_mem_addr", 64'(mem_addr), 64'h40);
    step();
    m1_req = 1'b0; m1_ren = 1'b0; m1_addr = '0;
    smp();
    chk("s4_hold_gnt", 64'(m0_gnt),   64'd0);
    chk("s4_hold_wen", 64'(mem_wen),  64'd0);
    chk("s4_hold_addr",64'(mem_addr), 64'h40);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    smp();
    chk("s4_hold_gnt2",64'(m0_gnt),    64'd0);
    chk("s4_rv_early", 64'(m1_rvalid), 64'd0);
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("s4_m1_rvalid", 64'(m1_rvalid), 64'd1);
    chk("s4_m1_rdata",  64'(m1_rdata),  64'hCAFE);
    chk("s4_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("s4_m0_gnt",    64'(m0_gnt),    64'd1);
    chk("s4_wr_wen",    64'(mem_wen),   64'd3);
    chk("s4_wr_addr",   64'(mem_addr),  64'h100);
    chk("s4_wr_data",   64'(mem_wdata), 64'hA5A5);
    step();
    idle_inputs();
    smp();
    chk("s4_rv_pulse", 64'(m1_rvalid), 64'd0);
    chk("s4_wr_once",  64'(mem_wen),   64'd0);

    // S5: read that memory never answers
    step();
    m0_req = 1'b1; m0_ren = 1'b1; m0_addr = 32'h80;
    smp();
    chk("s5_m0_gnt", 64'(m0_gnt), 64'd1);
    step();
    idle_inputs();
    n_busy = 0; rv_seen = 1'b0; err_early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!busy) break;
      n_busy++;
      if (m0_rvalid || m1_rvalid) rv_seen = 1'b1;
      if (err_timeout) err_early = 1'b1;
      step();
    end
    chk("s5_wait_cycles", 64'(n_busy),      64'd16);
    chk("s5_err_early",   64'(err_early),   64'd0);
    chk("s5_no_rvalid",   64'(rv_seen),     64'd0);
    chk("s5_err_set",     64'(err_timeout), 64'd1);
    chk("s5_no_rvalid2",  64'(m0_rvalid),   64'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("s5_late_ignored", 64'(m0_rvalid), 64'd0);
    step();
    m1_req = 1'b1; m1_wen = 2'b01; m1_addr = 32'h300;
    smp();
    chk("s5_next_gnt",   64'(m1_gnt),      64'd1);
    chk("s5_next_wen",   64'(mem_wen),     64'd1);
    chk("s5_err_sticky", 64'(err_timeout), 64'd1);
    step();
    idle_inputs();

    // S6: reset in the middle of a read, memory answers afterwards
    step();
    m0_req = 1'b1; m0_ren = 1'b1; m0_addr = 32'h20;
    smp();
    chk("s6_m0_gnt", 64'(m0_gnt), 64'd1);
    step();
    idle_inputs();
    smp();
    chk("s6_busy", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("s6_rst_busy", 64'(busy),        64'd0);
    chk("s6_rst_addr", 64'(mem_addr),    64'd0);
    chk("s6_rst_err",  64'(err_timeout), 64'd0);
    chk("s6_rst_ren",  64'(mem_ren),     64'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
    step();
    reset = 1'b1;
    smp();
    chk("s6_post_busy", 64'(busy), 64'd0);
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("s6_no_m0_rvalid", 64'(m0_rvalid), 64'd0);
      chk("s6_no_m1_rvalid", 64'(m1_rvalid), 64'd0);
      step();
    end

    // S2/S3: both masters write every cycle; round-robin vs m0 priority
    m0_req = 1'b1; m0_wen = 2'b01; m0_addr = 32'h100; m0_wdata = 32'h1111;
    m1_req = 1'b1; m1_wen = 2'b10; m1_addr = 32'h200; m1_wdata = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("s2_m0_gnt",   64'(m0_gnt),     (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("s2_m1_gnt",   64'(m1_gnt),     (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("s2_mem_addr", 64'(mem_addr),   (i % 2 == 0) ? 64'h100 : 64'h200);
      chk("s2_wen_nz",   64'(mem_wen != 2'b00), 64'd1);
      chk("s3_m0_gnt",   64'(p_m0_gnt),   64'd1);
      chk("s3_m1_gnt",   64'(p_m1_gnt),   64'd0);
      chk("s3_mem_addr", 64'(p_mem_addr), 64'h100);
      step();
    end
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
